// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; results land WIDTH cycles after start.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               is_div_reg, is_div_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic               div0_reg, div0_next;
  logic [WIDTH-1:0]   a_raw_reg, a_raw_next;
  logic [WIDTH-1:0]   addend_reg, addend_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Signedness comes from op[0]: 0 = signed variant
  always_comb begin
    sign_a = ~op[0] & a[WIDTH-1];
    sign_b = ~op[0] & b[WIDTH-1];
    mag_a  = sign_a ? (~a + 1'b1) : a;
    mag_b  = sign_b ? (~b + 1'b1) : b;
  end

  // Multiply: acc = {partial, multiplier}; add on lsb, then shift right with carry.
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract, restore.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, addend_reg} : '0);
    mul_step  = {mul_sum, acc_reg[WIDTH-1:1]};
    rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, addend_reg};
    if (!rem_diff[WIDTH])
      div_step = {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    else
      div_step = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    step     = is_div_reg ? div_step : mul_step;
    prod_fix = neg_q_reg ? (~step + 1'b1) : step;
    quot_fix = neg_q_reg ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0];
    rem_fix  = neg_r_reg ? (~step[2*WIDTH-1:WIDTH] + 1'b1) : step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    is_div_next = is_div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    div0_next   = div0_reg;
    a_raw_next  = a_raw_reg;
    addend_next = addend_reg;
    acc_next    = acc_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = BUSY;
          cnt_next    = CW'(WIDTH);
          is_div_next = op[1];
          neg_q_next  = sign_a ^ sign_b;
          neg_r_next  = sign_a;
          div0_next   = op[1] && (b == '0);
          a_raw_next  = a;
          addend_next = op[1] ? mag_b : mag_a;
          acc_next    = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        end else begin
          if (mthi) hi_next = wdata;
          if (mtlo) lo_next = wdata;
        end
      end
      BUSY: begin
        acc_next = step;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
          if (div0_reg) begin
            hi_next = a_raw_reg;
            lo_next = '1;
          end else if (is_div_reg) begin
            hi_next = rem_fix;
            lo_next = quot_fix;
          end else begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      a_raw_reg  <= '0;
      addend_reg <= '0;
      acc_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      is_div_reg <= is_div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      div0_reg   <= div0_next;
      a_raw_reg  <= a_raw_next;
      addend_reg <= addend_next;
      acc_reg    <= acc_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
    end
  end

  assign busy = (state_reg == BUSY);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: expected HI/LO results are queued at
// start and compared when the done pulse appears.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   tests  = 0;
  int   failed = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the accepting edge is the following posedge.
  task automatic start_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    op = o; a = x; b = y; start = 1'b1;
    e.tag = tag; e.hi = eh; e.lo = el;
    sb_q.push_back(e);
    $display("[TB] start %s op=%0d a=%h b=%h", tag, o, x, y);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle. disturb_at>0 pokes start/mthi/mtlo/a/b mid-operation.
  task automatic wait_done(input int disturb_at, input logic [31:0] held_hi);
    int   bcyc = 0;
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
      end else begin
        if (busy) bcyc++;
        if (disturb_at > 0 && busy && bcyc == disturb_at) begin
          check("hi_held_busy", {32'h0, hi}, {32'h0, held_hi});
          start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555_5555;
          a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 2'b00;
        end else if (disturb_at > 0 && bcyc == disturb_at + 1) begin
          start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        end
      end
    end
    check("done_seen", {63'h0, seen}, 64'h1);
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, "_busy_cycles"}, 64'(bcyc), 64'd32);
      check({e.tag, "_busy_low"}, {63'h0, busy}, 64'h0);
      check({e.tag, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
      check({e.tag, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
      $display("[TB] done %s hi=%h lo=%h busy_cycles=%0d", e.tag, hi, lo, bcyc);
    end
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);

    start_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done(0, 32'h0);
    @(negedge clk);
    check("done_one_cycle", {63'h0, done}, 64'h0);

    start_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done(0, 32'h0);
    start_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done(0, 32'h0);

    start_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done(0, 32'h0);
    start_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_done(0, 32'h0);
    start_op("divu_by0", 2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_done(0, 32'h0);
    start_op("div_by0", 2'b10, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    wait_done(0, 32'h0);

    // MTHI then MTLO in idle
    @(negedge clk);
    mthi = 1'b1; wdata = 32'hAAAA_0000;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", {32'h0, hi}, 64'h0000_0000_AAAA_0000);
    check("mthi_lo_kept", {32'h0, lo}, 64'h0000_0000_FFFF_FFFF);
    mtlo = 1'b1; wdata = 32'h0000_BBBB;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", {32'h0, lo}, 64'h0000_0000_0000_BBBB);
    check("mtlo_hi_kept", {32'h0, hi}, 64'h0000_0000_AAAA_0000);
    $display("[TB] mthi/mtlo hi=%h lo=%h", hi, lo);

    // start wins over mtlo in the same cycle; inputs poked mid-operation are ignored
    mtlo = 1'b1; wdata = 32'h1111_1111;
    start_op("multu_3x4_disturbed", 2'b01, 32'd3, 32'd4, 32'h0, 32'd12);
    mtlo = 1'b0;
    wait_done(5, 32'hAAAA_0000);
    @(negedge clk);
    check("no_restart", {63'h0, busy}, 64'h0);

    // reset during BUSY aborts with no result
    op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
    $display("[TB] start mult_6x7 (abort by reset)");
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_hi", {32'h0, hi}, 64'h0);
    check("abort_lo", {32'h0, lo}, 64'h0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'h0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("[TB] abort hi=%h lo=%h done_pulses=%0d", hi, lo, dcount);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. It executes MULT, MULTU, DIV and DIVU over WIDTH cycles, with the EX stage held on busy. It also services MTHI/MTLO. Its hi/lo outputs feed the EX-stage result-select mux for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
mthi  input  1  write wdata to hi; honoured only in IDLE
mtlo  input  1  write wdata to lo; honoured only in IDLE
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress; pipeline must stall EX while high
done  output  1  one-cycle pulse when hi/lo receive a result
hi  output  WIDTH  HI register (product high half / remainder)
lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset during BUSY aborts the operation; no partial result reaches hi/lo.
- States: IDLE, BUSY.
- IDLE to BUSY: at an edge with start=1. Latch op, a, b, and the operand signs. For signed ops, convert operands to magnitudes. Load the counter with WIDTH. Later changes on a, b and op have no effect.
- In BUSY, each edge performs one iteration and decrements the counter.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes; 1 quotient bit per cycle.
- BUSY to IDLE: on the edge where the counter reaches 0, which is the WIDTH-th edge after acceptance. On that edge, write hi/lo with the final, sign-corrected result, clear busy, and set done for exactly one cycle.
- Latency: busy=1 for exactly WIDTH cycles. hi/lo are valid, and done=1, in the cycle after busy falls. A new start is accepted in that same cycle.
- Sign rules:
  - MULT: product is negated if sign(a) XOR sign(b).
  - DIV: quotient is negated if sign(a) XOR sign(b); remainder takes sign(a).
  - Unsigned ops: no correction.
- Division by zero (b=0, DIV or DIVU): same WIDTH-cycle latency. lo = all ones; hi = a, unmodified.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the magnitude path with no special case.
- During BUSY: start, mthi and mtlo are ignored; hi and lo hold their previous values.
- MTHI/MTLO in IDLE: the register updates at the next edge. mthi and mtlo together write both registers. If start is also high in the same cycle, start wins and mthi/mtlo are ignored.
- done is 0 in all cycles except the single completion cycle.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> busy high 32 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; back-to-back DIVU 100/7 started in the done cycle -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x12345678.
- mthi wdata=0xAAAA0000 in IDLE -> hi=0xAAAA0000 next cycle. During BUSY, pulse start, mthi and mtlo and change a/b -> all ignored; result unaffected; hi holds 0xAAAA0000 until completion.
- Start MULT 6*7, assert rst at BUSY cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse appears afterwards.
